// File: rtl/cfg_chain_loader.sv
// rtl/cfg_chain_loader.sv - configuration scan-chain bitstream loader
// Serialises stream words LSB-first into the config flop chain, then pulses cfg_en.
module cfg_chain_loader #(
  parameter int CHAIN_LEN   = 256,
  parameter int WORD_W      = 8,
  parameter int CFGE_CYCLES = 2
) (
  input  logic              CK,
  input  logic              RST,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              sc_in,
  output logic              sc_en,
  output logic              sc_clk_en,
  output logic              cfg_en,
  output logic              cfg_done,
  output logic              busy
);

  localparam int TOT_W = $clog2(CHAIN_LEN + 1);
  localparam int WB_W  = $clog2(WORD_W + 1);
  localparam int CC_W  = $clog2(CFGE_CYCLES + 1);

  localparam logic [TOT_W-1:0] LP_TOT_LAST = TOT_W'(CHAIN_LEN - 1);
  localparam logic [WB_W-1:0]  LP_WB_LAST  = WB_W'(WORD_W - 1);
  localparam logic [CC_W-1:0]  LP_CC_LAST  = CC_W'(CFGE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SHIFT  = 3'd2,
    S_COMMIT = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [WORD_W-1:0] r_shreg;
  logic [TOT_W-1:0]  r_tot;
  logic [WB_W-1:0]   r_wbit;
  logic [CC_W-1:0]   r_ccnt;
  logic              w_clear;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_LOAD;
      end
      S_LOAD: begin
        if (abort)          w_next = S_IDLE;
        else if (din_valid) w_next = S_SHIFT;
      end
      S_SHIFT: begin
        // Chain-length limit wins over word boundary: leftover word bits are dropped.
        if (abort)                     w_next = S_IDLE;
        else if (r_tot == LP_TOT_LAST) w_next = S_COMMIT;
        else if (r_wbit == LP_WB_LAST) w_next = S_LOAD;
      end
      S_COMMIT: begin
        if (abort)                      w_next = S_IDLE;
        else if (r_ccnt == LP_CC_LAST)  w_next = S_DONE;
      end
      S_DONE: begin
        if (start) w_next = S_LOAD;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_clear = (w_next == S_IDLE) ||
                   ((w_next == S_LOAD) && ((r_state == S_IDLE) || (r_state == S_DONE)));

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_shreg <= '0;
      r_tot   <= '0;
      r_wbit  <= '0;
      r_ccnt  <= '0;
    end else begin
      r_state <= w_next;
      if (w_clear) begin
        r_shreg <= '0;
        r_tot   <= '0;
        r_wbit  <= '0;
        r_ccnt  <= '0;
      end else if ((r_state == S_LOAD) && din_valid) begin
        r_shreg <= din;
        r_wbit  <= '0;
      end else if (r_state == S_SHIFT) begin
        r_shreg <= r_shreg >> 1;
        r_tot   <= r_tot + TOT_W'(1);
        r_wbit  <= r_wbit + WB_W'(1);
      end else if (r_state == S_COMMIT) begin
        r_ccnt  <= r_ccnt + CC_W'(1);
      end
    end
  end

  // Outputs are pure state decode so no input reaches an output combinationally.
  always_comb begin
    din_ready = (r_state == S_LOAD);
    sc_en     = (r_state == S_SHIFT);
    sc_clk_en = (r_state == S_SHIFT);
    sc_in     = (r_state == S_SHIFT) && r_shreg[0];
    cfg_en    = (r_state == S_COMMIT);
    cfg_done  = (r_state == S_DONE);
    busy      = (r_state == S_LOAD) || (r_state == S_SHIFT) || (r_state == S_COMMIT);
  end

endmodule

// File: tb/tb_cfg_chain_loader.sv
// tb/tb_cfg_chain_loader.sv - directed bench for cfg_chain_loader
// Two instances (16-bit and 12-bit chains); sel routes stimulus and observation.
module tb_cfg_chain_loader;

  logic       CK = 1'b0;
  logic       RST;
  logic       sel;
  logic       start;
  logic       abort;
  logic       din_valid;
  logic [7:0] din;
  wire  [6:0] o16;
  wire  [6:0] o12;
  wire  [6:0] w_outs = sel ? o12 : o16;

  int n_total = 0;
  int n_bad   = 0;

  always #5 CK = ~CK;

  cfg_chain_loader #(.CHAIN_LEN(16), .WORD_W(8), .CFGE_CYCLES(2)) u_dut16 (
    .CK(CK), .RST(RST),
    .start(start & ~sel), .abort(abort & ~sel),
    .din(din), .din_valid(din_valid & ~sel),
    .din_ready(o16[6]), .sc_in(o16[5]), .sc_en(o16[4]), .sc_clk_en(o16[3]),
    .cfg_en(o16[2]), .cfg_done(o16[1]), .busy(o16[0])
  );

  cfg_chain_loader #(.CHAIN_LEN(12), .WORD_W(8), .CFGE_CYCLES(2)) u_dut12 (
    .CK(CK), .RST(RST),
    .start(start & sel), .abort(abort & sel),
    .din(din), .din_valid(din_valid & sel),
    .din_ready(o12[6]), .sc_in(o12[5]), .sc_en(o12[4]), .sc_clk_en(o12[3]),
    .cfg_en(o12[2]), .cfg_done(o12[1]), .busy(o12[0])
  );

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Entered and left at 1ns after a rising edge; cycle 1 is the cycle start is high.
  task automatic run_load(input logic [7:0] w0, input logic [7:0] w1, input int gap,
                          input int abort_at, input bit pulse_start, input bit abort_with_start,
                          output logic [15:0] bits, output int npulse, output int ncfge,
                          output int done_cyc, output int nacc, output logic [6:0] c2,
                          output int bad_cyc);
    int cyc;
    int gapleft;
    bits = '0; npulse = 0; ncfge = 0; done_cyc = 0; nacc = 0; c2 = '0; bad_cyc = 0;
    gapleft = gap;
    cyc = 1;
    start = 1'b1; abort = abort_with_start; din_valid = 1'b1; din = w0;
    while (done_cyc == 0 && cyc < 300) begin
      if (cyc == 2) c2 = w_outs;
      if (w_outs[4] !== w_outs[3]) bad_cyc++;
      if (w_outs[3]) begin
        if (npulse < 16) bits[npulse[3:0]] = w_outs[5];
        npulse++;
      end
      if (w_outs[2]) ncfge++;
      if (w_outs[1] && cyc > 1) done_cyc = cyc;
      if (cyc > 1) begin
        start = pulse_start && w_outs[0] && (cyc % 4 == 0);
        abort = 1'b0;
      end
      if (w_outs[6] && nacc == 1 && gapleft > 0) begin
        din_valid = 1'b0;
        gapleft--;
        if (w_outs[3] || w_outs[4]) bad_cyc++;
      end else begin
        din_valid = 1'b1;
        din = (nacc == 0) ? w0 : (nacc == 1) ? w1 : 8'h00;
        if (w_outs[6]) nacc++;
      end
      if (abort_at > 0 && npulse == abort_at && w_outs[3]) begin
        abort = 1'b1;
        done_cyc = -1;
      end
      if (done_cyc <= 0) begin
        @(posedge CK); #1;
        cyc++;
      end
      if (done_cyc < 0) break;
    end
    start = 1'b0; abort = 1'b0; din_valid = 1'b0;
  endtask

  logic [15:0] bits;
  logic [6:0]  c2;
  int          np, nc, dc, na, bc;

  initial begin
    RST = 1'b1; sel = 1'b0; start = 1'b0; abort = 1'b0; din_valid = 1'b0; din = 8'h00;
    repeat (3) @(posedge CK);
    #1 RST = 1'b0;
    chk_val("reset_o16", 32'(o16), 32'h0);
    chk_val("reset_o12", 32'(o12), 32'h0);

    // A5 then 3C, valid held high
    run_load(8'hA5, 8'h3C, 0, 0, 1'b0, 1'b0, bits, np, nc, dc, na, c2, bc);
    chk_val("t1_bits", 32'(bits), 32'h3CA5);
    chk_val("t1_pulses", 32'(np), 32'd16);
    chk_val("t1_cfge", 32'(nc), 32'd2);
    chk_val("t1_done_cyc", 32'(dc), 32'd22);
    chk_val("t1_words", 32'(na), 32'd2);
    chk_val("t1_load_outs", 32'(c2), 32'h41);
    chk_val("t1_ctl", 32'(bc), 32'd0);

    // abort in DONE must not disturb cfg_done
    abort = 1'b1;
    @(posedge CK); #1 abort = 1'b0;
    chk_val("done_abort_ign", 32'(w_outs), 32'h02);

    // start in DONE restarts a full load
    run_load(8'hA5, 8'h3C, 0, 0, 1'b0, 1'b0, bits, np, nc, dc, na, c2, bc);
    chk_val("t6_c2_outs", 32'(c2), 32'h41);
    chk_val("t6_bits", 32'(bits), 32'h3CA5);
    chk_val("t6_done_cyc", 32'(dc), 32'd22);

    // 5-cycle din_valid gap before second word
    run_load(8'hA5, 8'h3C, 5, 0, 1'b0, 1'b0, bits, np, nc, dc, na, c2, bc);
    chk_val("t3_bits", 32'(bits), 32'h3CA5);
    chk_val("t3_pulses", 32'(np), 32'd16);
    chk_val("t3_done_cyc", 32'(dc), 32'd27);
    chk_val("t3_gap_hold", 32'(bc), 32'd0);

    // abort after 5 shifted bits
    run_load(8'hA5, 8'h3C, 0, 5, 1'b0, 1'b0, bits, np, nc, dc, na, c2, bc);
    chk_val("t4_abort_outs", 32'(w_outs), 32'h0);
    chk_val("t4_pulses", 32'(np), 32'd5);
    repeat (3) @(posedge CK);
    #1 chk_val("t4_idle_hold", 32'(w_outs), 32'h0);
    // start with abort in IDLE: start wins
    run_load(8'h5A, 8'hC3, 0, 0, 1'b0, 1'b1, bits, np, nc, dc, na, c2, bc);
    chk_val("t4_c2_outs", 32'(c2), 32'h41);
    chk_val("t4_bits", 32'(bits), 32'hC35A);
    chk_val("t4_done_cyc", 32'(dc), 32'd22);

    // asynchronous reset mid-shift
    start = 1'b1;
    @(posedge CK); #1 start = 1'b0; din_valid = 1'b1; din = 8'hA5;
    repeat (4) @(posedge CK);
    #1 chk_val("t5_pre_shift", 32'(w_outs[3]), 32'h1);
    #2 RST = 1'b1;
    #1 chk_val("t5_async_outs", 32'(w_outs), 32'h0);
    @(posedge CK); #1 RST = 1'b0; din_valid = 1'b0;
    chk_val("t5_post_outs", 32'(w_outs), 32'h0);
    run_load(8'hA5, 8'h3C, 0, 0, 1'b1, 1'b0, bits, np, nc, dc, na, c2, bc);
    chk_val("t5_bits", 32'(bits), 32'h3CA5);
    chk_val("t5_pulses", 32'(np), 32'd16);
    chk_val("t5_done_cyc", 32'(dc), 32'd22);

    // 12-bit chain: second word only partly shifted
    sel = 1'b1;
    #1 chk_val("t2_idle", 32'(w_outs), 32'h0);
    run_load(8'hA5, 8'h0F, 0, 0, 1'b0, 1'b0, bits, np, nc, dc, na, c2, bc);
    chk_val("t2_bits", 32'(bits), 32'h0FA5);
    chk_val("t2_pulses", 32'(np), 32'd12);
    chk_val("t2_words", 32'(na), 32'd2);
    chk_val("t2_cfge", 32'(nc), 32'd2);
    chk_val("t2_done_cyc", 32'(dc), 32'd18);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
